// File: rtl/dmem_responder.sv
// dmem_responder: slow-memory model for the core's data port.
// Accepts one word load/store per transaction, waits WAIT_CYCLES cycles,
// then returns load data and an error flag over a valid/ready channel.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state, state_nx;
    req_t              lat, cur;
    logic [3:0]        cnt;
    logic [31:0]       offset;
    logic              dec_err;
    logic [ADDR_W-1:0] idx;
    logic              accept, enter_resp, resp_done;
    logic [31:0]       mem [2**ADDR_W];

    // With zero wait states the decode happens on the acceptance edge, so
    // it must look at the live request rather than the latched copy.
    always_comb begin
        cur = lat;
        if (state == S_IDLE)
            cur = '{write: req_write, addr: req_addr, wdata: req_wdata};
    end

    // Address decode: alignment, below-base and above-top checks.
    always_comb begin
        offset  = cur.addr - BASE_ADDR;
        dec_err = (cur.addr[1:0] != 2'b00) || (cur.addr < BASE_ADDR) ||
                  ((offset >> (ADDR_W + 2)) != 32'd0);
        idx     = offset[ADDR_W+1:2];
    end

    // Transaction events shared by the FSM and datapath.
    always_comb begin
        accept     = (state == S_IDLE) && req_valid;
        enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd1));
        resp_done  = (state == S_RESP) && resp_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (req_valid) state_nx = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt == 4'd1) state_nx = S_RESP;
            S_RESP: if (resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs follow the state directly.
    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_RESP);
    end

    // Request latch, wait counter and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat        <= '0;
            cnt        <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat <= cur;
                cnt <= WAIT_INIT;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                resp_err   <= dec_err;
                resp_rdata <= (dec_err || cur.write) ? 32'd0 : mem[idx];
            end else if (resp_done) begin
                resp_err   <= 1'b0;
                resp_rdata <= 32'd0;
            end
        end
    end

    // Storage array; never cleared. A store commits only on its RESP entry
    // edge, so a reset before that edge drops it.
    always_ff @(posedge clk) begin
        if (enter_resp && cur.write && !dec_err && reset)
            mem[idx] <= cur.wdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances with different wait/base
// settings, directed scenarios followed by randomized transactions checked
// against an address-keyed memory model.
module tb_dmem_responder;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic        req_write  [N];
    logic [31:0] req_addr   [N];
    logic [31:0] req_wdata  [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [31:0] resp_rdata [N];
    logic        resp_err   [N];

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    logic [31:0] mdl [longint unsigned];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned WC = (g == 0) ? 2 : (g == 1) ? 0 : 3;
        localparam logic [31:0] BA = (g == 2) ? 32'h0000_0100 : 32'h0;
        dmem_responder #(.ADDR_W(10), .BASE_ADDR(BA), .WAIT_CYCLES(WC)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    function automatic int wait_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 0 : 3;
    endfunction

    function automatic logic [31:0] base_of(input int i);
        return (i == 2) ? 32'h0000_0100 : 32'h0;
    endfunction

    // Reference decode: legal iff aligned and inside [base, base + 4*1024).
    function automatic bit model_err(input int i, input logic [31:0] a);
        logic [31:0] b;
        b = base_of(i);
        return (a[1:0] != 2'b00) || (a < b) || (((a - b) >> 2) >= 32'd1024);
    endfunction

    function automatic longint unsigned key_of(input int i, input logic [31:0] a);
        return longint'(i) * 64'd4096 + longint'((a - base_of(i)) >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_req_ready"},  32'(req_ready[i]),  32'd1);
            chk({tag, "_resp_valid"}, 32'(resp_valid[i]), 32'd0);
            chk({tag, "_resp_rdata"}, resp_rdata[i],      32'd0);
            chk({tag, "_resp_err"},   32'(resp_err[i]),   32'd0);
        end
    endtask

    // One full transaction on instance i; entered and left at #1 after a
    // rising edge with the instance idle.
    task automatic do_txn(input int i, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, input bit pulse);
        int          n;
        bit          e, known;
        logic [31:0] exp_rd;
        e = model_err(i, a);
        known = 1'b1;
        exp_rd = 32'd0;
        if (!e && !wr) begin
            known = mdl.exists(key_of(i, a));
            if (known) exp_rd = mdl[key_of(i, a)];
        end
        chk("idle_ready", 32'(req_ready[i]), 32'd1);
        req_write[i] = wr;
        req_addr[i]  = a;
        req_wdata[i] = wd;
        req_valid[i] = 1'b1;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
        req_write[i] = $urandom_range(0, 1);
        n = 0;
        while (!resp_valid[i] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(wait_of(i)));
        if (!e && wr) mdl[key_of(i, a)] = wd;
        chk("resp_err", 32'(resp_err[i]), 32'(e));
        if (known) chk("resp_rdata", resp_rdata[i], exp_rd);
        chk("resp_ready_low", 32'(req_ready[i]), 32'd0);
        for (int h = 0; h < hold; h++) begin
            if (pulse) begin
                req_valid[i] = 1'b1;
                req_write[i] = 1'b1;
                req_addr[i]  = a;
                req_wdata[i] = 32'h5A5A_A5A5;
            end
            @(posedge clk); #1;
            chk("hold_valid", 32'(resp_valid[i]), 32'd1);
            chk("hold_ready", 32'(req_ready[i]),  32'd0);
            chk("hold_err",   32'(resp_err[i]),   32'(e));
            if (known) chk("hold_rdata", resp_rdata[i], exp_rd);
        end
        req_valid[i]  = 1'b0;
        resp_ready[i] = 1'b1;
        @(posedge clk); #1;
        resp_ready[i] = 1'b0;
        chk("done_valid", 32'(resp_valid[i]), 32'd0);
        chk("done_ready", 32'(req_ready[i]),  32'd1);
        chk("done_rdata", resp_rdata[i],      32'd0);
        chk("done_err",   32'(resp_err[i]),   32'd0);
        if (pulse) begin
            @(posedge clk); #1;
            chk("no_phantom", 32'(resp_valid[i]), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic [31:0] tp_val [4];
        for (int i = 0; i < N; i++) begin
            req_valid[i]  = 1'b0;
            req_write[i]  = 1'b0;
            req_addr[i]   = 32'd0;
            req_wdata[i]  = 32'd0;
            resp_ready[i] = 1'b0;
        end
        #12;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Store then load, inst0 (2 wait states, base 0).
        do_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        // Misaligned accesses, then confirm the word survived.
        do_txn(0, 1'b0, 32'h13, 32'h0, 0, 1'b0);
        do_txn(0, 1'b1, 32'h12, 32'h1234_5678, 0, 1'b0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        chk("misaligned_store_dropped", mdl[key_of(0, 32'h10)], 32'hDEAD_BEEF);
        // Range boundaries.
        do_txn(0, 1'b0, 32'h1000, 32'h0, 0, 1'b0);
        do_txn(0, 1'b0, 32'hFFC, 32'h0, 0, 1'b0);
        do_txn(2, 1'b0, 32'hFC, 32'h0, 0, 1'b0);
        do_txn(2, 1'b1, 32'h100, 32'hCAFE_0001, 0, 1'b0);
        do_txn(2, 1'b0, 32'h100, 32'h0, 0, 1'b0);
        // Backpressure with an ignored request pulse.
        do_txn(0, 1'b0, 32'h10, 32'h0, 5, 1'b1);
        do_txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);

        // Zero-wait back-to-back loads with resp_ready tied high.
        for (int w = 0; w < 4; w++) begin
            tp_val[w] = $urandom;
            do_txn(1, 1'b1, 32'(w * 4), tp_val[w], 0, 1'b0);
        end
        resp_ready[1] = 1'b1;
        req_valid[1]  = 1'b1;
        req_write[1]  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req_addr[1] = 32'((k / 2) * 4);
            @(posedge clk); #1;
            chk("b2b_valid", 32'(resp_valid[1]), 32'((k % 2) == 0));
            if ((k % 2) == 0) chk("b2b_rdata", resp_rdata[1], tp_val[k / 2]);
        end
        req_valid[1]  = 1'b0;
        resp_ready[1] = 1'b0;
        @(posedge clk); #1;

        // Reset during the wait of a store: store is not committed.
        do_txn(0, 1'b1, 32'h20, 32'h1111_2222, 0, 1'b0);
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h3333_4444;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk("abort_in_wait", 32'(req_ready[0]), 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_txn(0, 1'b0, 32'h20, 32'h0, 0, 1'b0);

        // Randomized traffic across all instances.
        for (int r = 0; r < 60; r++) begin
            int i;
            i = $urandom_range(0, N - 1);
            b = base_of(i);
            case ($urandom_range(0, 6))
                0, 1, 2: a = b + 32'(4 * $urandom_range(0, 15));
                3:       a = b + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
                4:       a = b + 32'(4 * 1023);
                5:       a = b + 32'(4 * 1024);
                default: a = b - 32'd4;
            endcase
            do_txn(i, 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
